gpib_source_handshake: RTL and testbench
========================================

// Module: gpib_source_handshake
// PURPOSE
//  Talker-side (source) three-wire handshake engine for the GPIB interface. Takes bytes from a valid/ready
//  stream, drives DIO and DAV/EOI, and paces transfers on listener NRFD/NDAC. It sits beside the role
//  decoder and is enabled by its talker output. All bus signals are logical active-high (1 = asserted).
// PARAMETERS
//  DATA_WIDTH      8       DIO width
//  T1_CYCLES       20      data-settle cycles between DIO driven and DAV asserted (>=1)
//  TIMEOUT_CYCLES  100000  max cycles waiting on a listener before abort (used only with GPIB_SRC_TIMEOUT_EN)
//  CNT_WIDTH       17      counter width; must hold max(T1_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           asynchronous active-high reset
//  tx_enable      in   1           talker role active
//  atn            in   1           attention (command mode); aborts data transfer
//  ifc            in   1           interface clear; aborts data transfer
//  nrfd           in   1           not ready for data (wired-OR of listeners)
//  ndac           in   1           not data accepted (wired-OR of listeners)
//  s_data         in   DATA_WIDTH  byte to send
//  s_last         in   1           byte is last of message (sent with EOI)
//  s_valid        in   1           s_data/s_last valid
//  s_ready        out  1           byte accepted on s_valid & s_ready
//  gpib_data_out  out  DATA_WIDTH  DIO drive value
//  gpib_data_oe   out  1           DIO output enable (tri-state control lives at top level)
//  dav_out        out  1           data valid
//  eoi_out        out  1           end-or-identify, valid while gpib_data_oe
//  busy           out  1           state != IDLE
//  err_no_listener out 1           1-cycle pulse: nrfd=0 and ndac=0 in WAIT_RFD
//  err_timeout    out  1           1-cycle pulse: listener wait exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: state IDLE; s_ready, gpib_data_out, gpib_data_oe, dav_out, eoi_out, busy, errors all 0.
//  States: IDLE -> SETTLE -> WAIT_RFD -> DAV -> RELEASE -> IDLE.
//  IDLE: s_ready = tx_enable & !atn & !ifc (combinational from state/inputs). On handshake, register byte
//   and s_last; next cycle oe=1, DIO/EOI driven, counter loaded, go SETTLE.
//  SETTLE: hold for exactly T1_CYCLES cycles, dav=0, then WAIT_RFD.
//  WAIT_RFD: nrfd=0 & ndac=1 -> DAV (dav_out=1 next cycle). nrfd=0 & ndac=0 -> err_no_listener pulse, IDLE.
//  DAV: dav_out=1; on ndac=0 -> RELEASE.
//  RELEASE: dav_out=0, DIO/EOI still driven; on ndac=1 -> IDLE, oe=0, eoi_out=0.
//  Min byte time: 1 (accept) + T1_CYCLES + 1 (WAIT_RFD) + 1 (DAV) + 1 (RELEASE) cycles with instant listener.
//  Back-to-back: s_ready may rise in the IDLE cycle following RELEASE; no combinational input->DAV path.
//  Abort: ifc | atn | !tx_enable in any non-IDLE state -> IDLE next edge; dav, oe, eoi drop to 0; byte dropped, no error pulse.
//  Simultaneous abort and error condition: abort wins, no error pulse.
//  Counter is never free-running; reloaded on every state entry. rst mid-transfer releases bus immediately.
// CONFIGURATION
//  GPIB_SRC_TIMEOUT_EN defined: WAIT_RFD, DAV and RELEASE each count cycles from entry; reaching
//   TIMEOUT_CYCLES -> err_timeout pulse, bus released, IDLE. Not defined: waits indefinitely, err_timeout tied 0.
// STRUCTURE
//  Shared include gpib_defs.vh: state encodings (localparams), GPIB_SRC_TIMEOUT_EN default, line-polarity notes
//  common with gpib_interface. One sub-module: gpib_cycle_timer (loadable down-counter, CNT_WIDTH, zero flag)
//  used for both settle and timeout.
// TESTING
//  T1=4, nrfd=0/ndac=1, send 0xA5 -> oe at +1, dav at accept+6, ndac=0 -> dav drops next cycle, ndac=1 -> IDLE.
//  3 bytes 0x01,0x02,0x03 last on 0x03 -> eoi_out=1 only with 0x03; listener holds nrfd=1 10 cycles -> dav held off.
//  nrfd=0, ndac=0 in WAIT_RFD -> err_no_listener one cycle, oe=0, s_ready re-asserts.
//  ifc pulse during DAV -> dav_out=0, oe=0 next edge, no error; atn=1 in IDLE -> s_ready=0.
//  Macro on, TIMEOUT_CYCLES=50, nrfd stuck 1 -> err_timeout at cycle 50 of WAIT_RFD; macro off -> still waiting at 200.
//  rst asserted in RELEASE -> all outputs 0 asynchronously, next byte after release completes normally.

Source files
------------

// File: rtl/gpib_source_handshake_pkg.sv
// ============================================================================
// gpib_source_handshake_pkg : shared state encoding for the GPIB source handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpib_source_handshake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WAIT_RFD = 3'd2,
    ST_DAV      = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // States in which the engine is waiting on listener lines.
  function automatic logic is_listener_wait(input state_t s);
    return (s == ST_WAIT_RFD) || (s == ST_DAV) || (s == ST_RELEASE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpib_source_handshake_cycle_timer.sv
// ============================================================================
// gpib_cycle_timer : loadable down-counter with zero flag (settle and timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpib_cycle_timer #(
  parameter int CNT_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/gpib_source_handshake.sv
// ============================================================================
// gpib_source_handshake : GPIB talker-side DAV/NRFD/NDAC handshake engine.
// Optional listener-wait timeout enabled by macro GPIB_SRC_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpib_source_handshake
  import gpib_source_handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int T1_CYCLES      = 20,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  atn,
  input  logic                  ifc,
  input  logic                  nrfd,
  input  logic                  ndac,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] gpib_data_out,
  output logic                  gpib_data_oe,
  output logic                  dav_out,
  output logic                  eoi_out,
  output logic                  busy,
  output logic                  err_no_listener,
  output logic                  err_timeout
);

  localparam logic [CNT_WIDTH-1:0] C_SETTLE_LOAD  = CNT_WIDTH'(T1_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  err_nl_q, err_nl_d;
  logic                  err_to_q, err_to_d;

  logic                  abort;
  logic                  timed_out;
  logic                  timer_load;
  logic [CNT_WIDTH-1:0]  timer_val;
  logic                  timer_zero;

  assign abort = ifc | atn | ~tx_enable;

`ifdef GPIB_SRC_TIMEOUT_EN
  assign timed_out = is_listener_wait(state_q) & timer_zero;
`else
  assign timed_out = 1'b0;
`endif

  assign s_ready = (state_q == ST_IDLE) & tx_enable & ~atn & ~ifc & ~rst;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    last_d   = last_q;
    err_nl_d = 1'b0;
    err_to_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          data_d  = s_data;
          last_d  = s_last;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort)           state_d = ST_IDLE;
        else if (timer_zero) state_d = ST_WAIT_RFD;
      end
      // Abort is checked first so it always suppresses the error pulses.
      ST_WAIT_RFD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!nrfd && ndac) begin
          state_d = ST_DAV;
        end else if (!nrfd && !ndac) begin
          err_nl_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (timed_out) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DAV: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!ndac) begin
          state_d = ST_RELEASE;
        end else if (timed_out) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ndac) begin
          state_d = ST_IDLE;
        end else if (timed_out) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change; settle gets T1, waits get the timeout.
  assign timer_load = (state_d != state_q);
  assign timer_val  = (state_d == ST_SETTLE) ? C_SETTLE_LOAD : C_TIMEOUT_LOAD;

  gpib_cycle_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (busy),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      err_nl_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      last_q   <= last_d;
      err_nl_q <= err_nl_d;
      err_to_q <= err_to_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign gpib_data_oe    = busy;
  assign gpib_data_out   = busy ? data_q : '0;
  assign dav_out         = (state_q == ST_DAV);
  assign eoi_out         = busy & last_q;
  assign err_no_listener = err_nl_q;
  assign err_timeout     = err_to_q;

endmodule

`default_nettype wire

// File: tb/tb_gpib_source_handshake.sv
// ============================================================================
// tb_gpib_source_handshake : directed bench with a DAV-edge byte scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpib_source_handshake;

  localparam int T1 = 4;
`ifdef GPIB_SRC_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 100000;
`endif

  logic       clk, rst, tx_enable, atn, ifc, nrfd, ndac;
  logic [7:0] s_data;
  logic       s_last, s_valid, s_ready;
  logic [7:0] gpib_data_out;
  logic       gpib_data_oe, dav_out, eoi_out, busy, err_no_listener, err_timeout;

  gpib_source_handshake #(
    .DATA_WIDTH     (8),
    .T1_CYCLES      (T1),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (17)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_enable       (tx_enable),
    .atn             (atn),
    .ifc             (ifc),
    .nrfd            (nrfd),
    .ndac            (ndac),
    .s_data          (s_data),
    .s_last          (s_last),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .gpib_data_out   (gpib_data_out),
    .gpib_data_oe    (gpib_data_oe),
    .dav_out         (dav_out),
    .eoi_out         (eoi_out),
    .busy            (busy),
    .err_no_listener (err_no_listener),
    .err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   tests = 0;
  int   fails = 0;
  logic dav_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every rising DAV presents one byte on the bus; it must match the oldest queued byte.
  always @(negedge clk) begin
    if (dav_out && !dav_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_dav", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_data", {24'd0, gpib_data_out}, {24'd0, sb_e.d});
        chk("sb_eoi", {31'd0, eoi_out}, {31'd0, sb_e.l});
        chk("sb_oe", {31'd0, gpib_data_oe}, 1);
      end
    end
    dav_prev = dav_out;
  end

  task automatic wait_dav();
    int n;
    n = 0;
    while (!dav_out && n < 100) begin
      tick();
      n++;
    end
    chk("dav_wait_bound", {31'd0, dav_out}, 1);
  endtask

  task automatic accept(input logic [7:0] d, input logic l, input bit expect_dav);
    int n;
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_s_ready", {31'd0, s_ready}, 1);
    if (expect_dav) sb_q.push_back('{d: d, l: l});
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  // Full byte with a cooperative listener that holds NRFD for 'hold' extra cycles.
  task automatic xfer(input logic [7:0] d, input logic l, input int hold);
    int cyc;
    nrfd = (hold > 0);
    ndac = 1'b1;
    accept(d, l, 1'b1);
    cyc = 1;
    chk("xfer_eoi_drive", {31'd0, eoi_out}, {31'd0, l});
    repeat (T1 + hold) begin
      tick();
      cyc++;
    end
    chk("xfer_dav_holdoff", {31'd0, dav_out}, 0);
    nrfd = 1'b0;
    while (!dav_out && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("xfer_latency", cyc, 6 + hold);
    ndac = 1'b0;
    nrfd = 1'b1;
    tick();
    chk("xfer_release_dav", {31'd0, dav_out}, 0);
    chk("xfer_release_oe", {31'd0, gpib_data_oe}, 1);
    ndac = 1'b1;
    tick();
    chk("xfer_done_oe", {31'd0, gpib_data_oe}, 0);
    chk("xfer_done_eoi", {31'd0, eoi_out}, 0);
    nrfd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_enable = 1'b0; atn = 1'b0; ifc = 1'b0;
    nrfd = 1'b1; ndac = 1'b1; s_data = 8'd0; s_last = 1'b0; s_valid = 1'b0;
    repeat (2) tick();
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_oe", {31'd0, gpib_data_oe}, 0);
    chk("rst_dav", {31'd0, dav_out}, 0);
    chk("rst_eoi", {31'd0, eoi_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {24'd0, gpib_data_out}, 0);
    chk("rst_errs", {30'd0, err_no_listener, err_timeout}, 0);

    rst = 1'b0; tx_enable = 1'b1; nrfd = 1'b0; ndac = 1'b1;
    tick();
    chk("idle_s_ready", {31'd0, s_ready}, 1);

    // 0xA5 with exact cycle timing
    sb_q.push_back('{d: 8'hA5, l: 1'b0});
    s_data = 8'hA5; s_last = 1'b0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("a5_oe_c1", {31'd0, gpib_data_oe}, 1);
    chk("a5_dav_c1", {31'd0, dav_out}, 0);
    chk("a5_s_ready_busy", {31'd0, s_ready}, 0);
    chk("a5_data_c1", {24'd0, gpib_data_out}, 32'hA5);
    repeat (4) tick();
    chk("a5_dav_c5", {31'd0, dav_out}, 0);
    tick();
    chk("a5_dav_c6", {31'd0, dav_out}, 1);
    ndac = 1'b0;
    tick();
    chk("a5_release_dav", {31'd0, dav_out}, 0);
    chk("a5_release_oe", {31'd0, gpib_data_oe}, 1);
    ndac = 1'b1;
    tick();
    chk("a5_idle_oe", {31'd0, gpib_data_oe}, 0);
    chk("a5_idle_busy", {31'd0, busy}, 0);
    chk("a5_back_to_back_ready", {31'd0, s_ready}, 1);

    // Three-byte message, EOI only on the last, NRFD hold-off on the middle byte
    xfer(8'h01, 1'b0, 0);
    xfer(8'h02, 1'b0, 10);
    xfer(8'h03, 1'b1, 0);

    // No listener: NRFD and NDAC both low in WAIT_RFD
    accept(8'h5A, 1'b0, 1'b0);
    nrfd = 1'b0; ndac = 1'b0;
    repeat (4) tick();
    chk("nl_before_err", {31'd0, err_no_listener}, 0);
    chk("nl_busy_wait", {31'd0, busy}, 1);
    tick();
    chk("nl_err_pulse", {31'd0, err_no_listener}, 1);
    chk("nl_oe", {31'd0, gpib_data_oe}, 0);
    chk("nl_s_ready", {31'd0, s_ready}, 1);
    tick();
    chk("nl_err_one_cycle", {31'd0, err_no_listener}, 0);
    ndac = 1'b1;

    // IFC pulse during DAV
    accept(8'h3C, 1'b1, 1'b1);
    wait_dav();
    ifc = 1'b1;
    tick();
    chk("ifc_dav", {31'd0, dav_out}, 0);
    chk("ifc_oe", {31'd0, gpib_data_oe}, 0);
    chk("ifc_eoi", {31'd0, eoi_out}, 0);
    chk("ifc_no_err", {30'd0, err_no_listener, err_timeout}, 0);
    ifc = 1'b0;
    tick();
    chk("ifc_no_err_after", {30'd0, err_no_listener, err_timeout}, 0);

    // ATN / talker-disable gate s_ready in IDLE
    atn = 1'b1;
    #1;
    chk("atn_s_ready", {31'd0, s_ready}, 0);
    atn = 1'b0; tx_enable = 1'b0;
    #1;
    chk("txen_s_ready", {31'd0, s_ready}, 0);
    tx_enable = 1'b1;
    tick();

    // Listener stuck not-ready
    nrfd = 1'b1;
    accept(8'h77, 1'b0, 1'b0);
`ifdef GPIB_SRC_TIMEOUT_EN
    repeat (53) tick();
    chk("tmo_before", {31'd0, err_timeout}, 0);
    chk("tmo_busy_before", {31'd0, busy}, 1);
    tick();
    chk("tmo_pulse", {31'd0, err_timeout}, 1);
    chk("tmo_oe", {31'd0, gpib_data_oe}, 0);
    chk("tmo_busy", {31'd0, busy}, 0);
    tick();
    chk("tmo_one_cycle", {31'd0, err_timeout}, 0);
`else
    repeat (199) tick();
    chk("notmo_busy_200", {31'd0, busy}, 1);
    chk("notmo_err_200", {31'd0, err_timeout}, 0);
    chk("notmo_dav_200", {31'd0, dav_out}, 0);
    tx_enable = 1'b0;
    tick();
    chk("notmo_abort_idle", {31'd0, busy}, 0);
    chk("notmo_abort_no_err", {30'd0, err_no_listener, err_timeout}, 0);
    tx_enable = 1'b1;
`endif
    nrfd = 1'b0;
    tick();

    // Reset asserted in RELEASE
    accept(8'hC3, 1'b1, 1'b1);
    wait_dav();
    ndac = 1'b0;
    tick();
    chk("rstrel_in_release", {31'd0, gpib_data_oe & ~dav_out}, 1);
    rst = 1'b1;
    #1;
    chk("rstrel_oe", {31'd0, gpib_data_oe}, 0);
    chk("rstrel_busy", {31'd0, busy}, 0);
    chk("rstrel_eoi", {31'd0, eoi_out}, 0);
    chk("rstrel_data", {24'd0, gpib_data_out}, 0);
    ndac = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    xfer(8'h99, 1'b1, 0);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
